// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, data-access and RAM-side signals of the shared memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  // instruction-fetch requester
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_pc;
  logic              i_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       i_rsp_instr;
  logic [1:0]        i_rsp_exc;

  // data-access requester
  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_data;
  logic [1:0]        d_req_memo;
  logic [MASK_W-1:0] d_req_mask;
  logic              d_rsp_valid;
  logic              d_rsp_ready;
  logic [DATA_W-1:0] d_rsp_data;
  logic [1:0]        d_rsp_exc;

  // RAM port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_exc;

  // arbiter view
  modport slave (
    input  i_req_valid, i_req_pc, i_rsp_ready,
    input  d_req_valid, d_req_addr, d_req_data, d_req_memo, d_req_mask, d_rsp_ready,
    input  mem_rdata, mem_exc,
    output i_req_ready, i_rsp_valid, i_rsp_instr, i_rsp_exc,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_exc,
    output mem_addr, mem_wdata, mem_mask, mem_wr
  );

  // requesters + RAM view
  modport master (
    output i_req_valid, i_req_pc, i_rsp_ready,
    output d_req_valid, d_req_addr, d_req_data, d_req_memo, d_req_mask, d_rsp_ready,
    output mem_rdata, mem_exc,
    input  i_req_ready, i_rsp_valid, i_rsp_instr, i_rsp_exc,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_exc,
    input  mem_addr, mem_wdata, mem_mask, mem_wr
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin share of one RAM port between fetch and data, 1-deep response slots
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus_if
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [0:0] LG_I = 1'b0;
  localparam logic [0:0] LG_D = 1'b1;

  localparam logic [1:0] EXC_OK = 2'b00;

  // response slot state and contents
  logic [0:0]        i_state_q, i_state_d;
  logic [0:0]        d_state_q, d_state_d;
  logic [0:0]        last_grant_q, last_grant_d;
  logic [31:0]       i_instr_q, i_instr_d;
  logic [1:0]        i_exc_q, i_exc_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic [1:0]        d_exc_q, d_exc_d;

  logic              i_elig;
  logic              d_elig;
  logic              grant_i;
  logic              grant_d;
  logic              d_is_store;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [MASK_W-1:0] mem_mask_c;
  logic              mem_wr_c;
  logic              memo_unused;

  assign d_is_store  = bus_if.d_req_memo[0];
  assign memo_unused = bus_if.d_req_memo[1];

  // A slot that is being drained this cycle can accept a new grant at once.
  assign i_elig = bus_if.i_req_valid &&
                  !((i_state_q == S_FULL) && !bus_if.i_rsp_ready);
  assign d_elig = bus_if.d_req_valid &&
                  !((d_state_q == S_FULL) && !bus_if.d_rsp_ready);

  // Grants are suppressed while reset is held so no write can land mid-reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset) begin
      if (i_elig && d_elig) begin
        if (last_grant_q == LG_I) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end
  end

  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_mask_c  = '0;
    mem_wr_c    = 1'b0;
    if (grant_i) begin
      mem_addr_c = bus_if.i_req_pc;
    end else if (grant_d) begin
      mem_addr_c  = bus_if.d_req_addr;
      mem_wdata_c = bus_if.d_req_data;
      mem_mask_c  = bus_if.d_req_mask;
      mem_wr_c    = d_is_store && (bus_if.mem_exc == EXC_OK);
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_d) begin
      last_grant_d = LG_D;
    end else if (grant_i) begin
      last_grant_d = LG_I;
    end
  end

  always_comb begin
    i_state_d = i_state_q;
    i_instr_d = i_instr_q;
    i_exc_d   = i_exc_q;
    case (i_state_q)
      S_EMPTY: begin
        if (grant_i) begin
          i_state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (bus_if.i_rsp_ready && !grant_i) begin
          i_state_d = S_EMPTY;
        end
      end
      default: i_state_d = S_EMPTY;
    endcase
    if (grant_i) begin
      i_instr_d = bus_if.mem_rdata[31:0];
      i_exc_d   = bus_if.mem_exc;
    end
  end

  always_comb begin
    d_state_d = d_state_q;
    d_data_d  = d_data_q;
    d_exc_d   = d_exc_q;
    case (d_state_q)
      S_EMPTY: begin
        if (grant_d) begin
          d_state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (bus_if.d_rsp_ready && !grant_d) begin
          d_state_d = S_EMPTY;
        end
      end
      default: d_state_d = S_EMPTY;
    endcase
    if (grant_d) begin
      d_data_d = d_is_store ? '0 : bus_if.mem_rdata;
      d_exc_d  = bus_if.mem_exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_state_q    <= S_EMPTY;
      d_state_q    <= S_EMPTY;
      last_grant_q <= LG_I;
      i_instr_q    <= '0;
      i_exc_q      <= '0;
      d_data_q     <= '0;
      d_exc_q      <= '0;
    end else begin
      i_state_q    <= i_state_d;
      d_state_q    <= d_state_d;
      last_grant_q <= last_grant_d;
      i_instr_q    <= i_instr_d;
      i_exc_q      <= i_exc_d;
      d_data_q     <= d_data_d;
      d_exc_q      <= d_exc_d;
    end
  end

  assign bus_if.i_req_ready = grant_i;
  assign bus_if.d_req_ready = grant_d;
  assign bus_if.i_rsp_valid = (i_state_q == S_FULL);
  assign bus_if.i_rsp_instr = i_instr_q;
  assign bus_if.i_rsp_exc   = i_exc_q;
  assign bus_if.d_rsp_valid = (d_state_q == S_FULL);
  assign bus_if.d_rsp_data  = d_data_q;
  assign bus_if.d_rsp_exc   = d_exc_q;
  assign bus_if.mem_addr    = mem_addr_c;
  assign bus_if.mem_wdata   = mem_wdata_c;
  assign bus_if.mem_mask    = mem_mask_c;
  assign bus_if.mem_wr      = mem_wr_c;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed scenarios plus randomized traffic against a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // RAM: 1 MiB, out-of-bounds above 20 bits, misaligned when low two bits set
  function automatic logic [1:0] ram_exc(input logic [63:0] a);
    if (a[63:20] != 44'd0) return 2'b10;
    if (a[1:0] != 2'd0) return 2'b01;
    return 2'b00;
  endfunction

  bit [63:0] ram     [0:131071];
  bit [63:0] ref_mem [0:131071];

  assign bus.mem_rdata = ram[bus.mem_addr[19:3]];
  assign bus.mem_exc   = ram_exc(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      logic [63:0] w;
      w = ram[bus.mem_addr[19:3]];
      for (int b = 0; b < 8; b++)
        if (bus.mem_mask[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      ram[bus.mem_addr[19:3]] <= w;
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          m_ifull, m_dfull, m_last_d;
  logic [31:0] m_iinstr;
  logic [63:0] m_ddata;
  logic [1:0]  m_iexc, m_dexc;

  initial begin : model
    logic        s_rst_n, s_iv, s_irr, s_dv, s_drr, wi, wd, exp_wr;
    logic [63:0] s_ipc, s_dad, s_dwd, exp_addr, rd, w;
    logic [7:0]  s_dmask;
    logic [1:0]  s_dmemo, exp_exc;
    int          pick;
    m_ifull = 0; m_dfull = 0; m_last_d = 0;
    m_iinstr = '0; m_ddata = '0; m_iexc = '0; m_dexc = '0;
    forever begin
      @(negedge clk);
      s_rst_n = reset;
      s_iv = bus.i_req_valid; s_ipc = bus.i_req_pc; s_irr = bus.i_rsp_ready;
      s_dv = bus.d_req_valid; s_dad = bus.d_req_addr; s_dwd = bus.d_req_data;
      s_dmask = bus.d_req_mask; s_dmemo = bus.d_req_memo; s_drr = bus.d_rsp_ready;
      wi = s_iv && (!m_ifull || s_irr);
      wd = s_dv && (!m_dfull || s_drr);
      pick = 0;
      if (s_rst_n) begin
        if (wi && wd) pick = m_last_d ? 1 : 2;
        else if (wd) pick = 2;
        else if (wi) pick = 1;
      end
      exp_addr = (pick == 1) ? s_ipc : ((pick == 2) ? s_dad : 64'h0);
      exp_exc  = ram_exc(exp_addr);
      exp_wr   = (pick == 2) && s_dmemo[0] && (exp_exc == 2'b00);
      chk("i_req_ready", 64'(bus.i_req_ready), 64'(pick == 1));
      chk("d_req_ready", 64'(bus.d_req_ready), 64'(pick == 2));
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wr", 64'(bus.mem_wr), 64'(exp_wr));
      if (pick == 2) begin
        chk("mem_wdata", bus.mem_wdata, s_dwd);
        chk("mem_mask", 64'(bus.mem_mask), 64'(s_dmask));
      end else begin
        chk("mem_mask_idle", 64'(bus.mem_mask), 64'h0);
      end
      chk("i_rsp_valid", 64'(bus.i_rsp_valid), 64'(s_rst_n && m_ifull));
      chk("i_rsp_instr", 64'(bus.i_rsp_instr), s_rst_n ? 64'(m_iinstr) : 64'h0);
      chk("i_rsp_exc", 64'(bus.i_rsp_exc), s_rst_n ? 64'(m_iexc) : 64'h0);
      chk("d_rsp_valid", 64'(bus.d_rsp_valid), 64'(s_rst_n && m_dfull));
      chk("d_rsp_data", bus.d_rsp_data, s_rst_n ? m_ddata : 64'h0);
      chk("d_rsp_exc", 64'(bus.d_rsp_exc), s_rst_n ? 64'(m_dexc) : 64'h0);
      @(posedge clk);
      if (!s_rst_n || !reset) begin
        m_ifull = 0; m_dfull = 0; m_last_d = 0;
        m_iinstr = '0; m_ddata = '0; m_iexc = '0; m_dexc = '0;
      end else begin
        rd = ref_mem[exp_addr[19:3]];
        if (pick == 1) begin
          m_ifull = 1; m_iinstr = rd[31:0]; m_iexc = exp_exc; m_last_d = 0;
        end else if (s_irr) m_ifull = 0;
        if (pick == 2) begin
          m_dfull = 1; m_ddata = s_dmemo[0] ? 64'h0 : rd; m_dexc = exp_exc; m_last_d = 1;
          if (exp_wr) begin
            w = rd;
            for (int b = 0; b < 8; b++) if (s_dmask[b]) w[8*b +: 8] = s_dwd[8*b +: 8];
            ref_mem[exp_addr[19:3]] = w;
          end
        end else if (s_drr) m_dfull = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic d_op(input logic [63:0] a, input logic [63:0] dat, input logic [7:0] msk,
                      input logic [1:0] memo, output logic [63:0] rdata,
                      output logic [1:0] exc, output logic wr_seen);
    bit got = 0;
    wr_seen = 0;
    bus.d_req_valid = 1; bus.d_req_addr = a; bus.d_req_data = dat;
    bus.d_req_mask = msk; bus.d_req_memo = memo; bus.d_rsp_ready = 1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.d_req_ready) begin got = 1; wr_seen = bus.mem_wr; end
    end
    if (!got) chk("d_grant_timeout", 64'h0, 64'h1);
    @(posedge clk); #1 bus.d_req_valid = 0;
    @(negedge clk);
    chk("d_op_rsp_valid", 64'(bus.d_rsp_valid), 64'h1);
    rdata = bus.d_rsp_data; exc = bus.d_rsp_exc;
    @(posedge clk); #1;
  endtask

  task automatic i_op(input logic [63:0] pc, output logic [31:0] instr, output logic [1:0] exc);
    bit got = 0;
    bus.i_req_valid = 1; bus.i_req_pc = pc; bus.i_rsp_ready = 1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.i_req_ready) got = 1;
    end
    if (!got) chk("i_grant_timeout", 64'h0, 64'h1);
    @(posedge clk); #1 bus.i_req_valid = 0;
    @(negedge clk);
    chk("i_op_rsp_valid", 64'(bus.i_rsp_valid), 64'h1);
    instr = bus.i_rsp_instr; exc = bus.i_rsp_exc;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] gen_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return 64'h1_0000_0000 + 64'($urandom_range(0, 7) * 8);
    if (r == 1) return 64'h100 + 64'($urandom_range(1, 3));
    return 64'h0E0 + 64'($urandom_range(0, 7) * 8);
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    logic [63:0] rdata;
    logic [31:0] instr;
    logic [1:0]  exc;
    logic        wrs;
    logic [1:0]  g;
    bit          gi, gd, got;
    bus.i_req_valid = 0; bus.i_req_pc = '0; bus.i_rsp_ready = 1;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_data = '0;
    bus.d_req_mask = '0; bus.d_req_memo = '0; bus.d_rsp_ready = 1;
    repeat (3) @(posedge clk);

    // reset held with both requesting
    #1 bus.i_req_valid = 1; bus.i_req_pc = 64'h0;
    bus.d_req_valid = 1; bus.d_req_addr = 64'h8;
    @(negedge clk);
    chk("t1_i_ready", 64'(bus.i_req_ready), 64'h0);
    chk("t1_d_ready", 64'(bus.d_req_ready), 64'h0);
    chk("t1_mem_wr", 64'(bus.mem_wr), 64'h0);
    chk("t1_rsp_valid", 64'({bus.i_rsp_valid, bus.d_rsp_valid}), 64'h0);
    @(posedge clk); #1 reset = 1;

    // contention: D first, strict alternation, response one cycle after grant
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g = bus.d_req_ready ? 2'd2 : (bus.i_req_ready ? 2'd1 : 2'd0);
      chk($sformatf("t2_grant%0d", k), 64'(g), (k % 2 == 0) ? 64'd2 : 64'd1);
      chk($sformatf("t2_dvalid%0d", k), 64'(bus.d_rsp_valid), 64'(k % 2 == 1));
      chk($sformatf("t2_ivalid%0d", k), 64'(bus.i_rsp_valid), 64'(k >= 2 && k % 2 == 0));
    end
    @(posedge clk); #1 bus.i_req_valid = 0; bus.d_req_valid = 0;
    repeat (2) @(posedge clk); #1;

    // store/load with partial mask
    d_op(64'h100, 64'hAABBCCDDEEFF0011, 8'hFF, 2'b01, rdata, exc, wrs);
    chk("t3_store_wr", 64'(wrs), 64'h1);
    chk("t3_store_data", rdata, 64'h0);
    d_op(64'h100, 64'h1122334455667788, 8'h0F, 2'b01, rdata, exc, wrs);
    d_op(64'h100, 64'h0, 8'h00, 2'b00, rdata, exc, wrs);
    chk("t3_load_data", rdata, 64'hAABBCCDD55667788);
    chk("t3_load_exc", 64'(exc), 64'h0);
    i_op(64'h100, instr, exc);
    chk("t3_fetch_instr", 64'(instr), 64'h55667788);

    // faults
    d_op(64'h1_0000_0000, 64'hDEAD, 8'hFF, 2'b01, rdata, exc, wrs);
    chk("t4_oob_wr", 64'(wrs), 64'h0);
    chk("t4_oob_exc", 64'(exc), 64'h2);
    i_op(64'h102, instr, exc);
    chk("t4_mis_exc", 64'(exc), 64'h1);

    // fetch backpressure
    bus.i_rsp_ready = 0; bus.d_rsp_ready = 1;
    bus.i_req_valid = 1; bus.i_req_pc = 64'h100;
    bus.d_req_valid = 1; bus.d_req_addr = 64'h108; bus.d_req_memo = 2'b00;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.i_req_ready) got = 1;
    end
    chk("t5_first_fetch", 64'(got), 64'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_i_blocked", 64'(bus.i_req_ready), 64'h0);
      chk("t5_d_granted", 64'(bus.d_req_ready), 64'h1);
      chk("t5_i_held", 64'(bus.i_rsp_valid), 64'h1);
      chk("t5_i_instr", 64'(bus.i_rsp_instr), 64'h55667788);
    end
    @(posedge clk); #1 bus.i_rsp_ready = 1;
    @(negedge clk);
    chk("t5_release_grant", 64'(bus.i_req_ready), 64'h1);
    @(negedge clk);
    chk("t5_b2b_valid", 64'(bus.i_rsp_valid), 64'h1);
    @(posedge clk); #1 bus.i_req_valid = 0; bus.d_req_valid = 0;
    repeat (2) @(posedge clk); #1;

    // reset during a store grant cycle
    bus.d_req_valid = 1; bus.d_req_addr = 64'h100; bus.d_req_data = 64'h0;
    bus.d_req_mask = 8'hFF; bus.d_req_memo = 2'b01;
    @(negedge clk);
    chk("t6_grant", 64'(bus.d_req_ready), 64'h1);
    chk("t6_wr_pre", 64'(bus.mem_wr), 64'h1);
    #2 reset = 0;
    #1;
    chk("t6_wr_rst", 64'(bus.mem_wr), 64'h0);
    chk("t6_rsp_rst", 64'({bus.i_rsp_valid, bus.d_rsp_valid}), 64'h0);
    @(posedge clk); #1;
    chk("t6_ram_kept", ram[32], 64'hAABBCCDD55667788);
    bus.d_req_valid = 0;
    @(posedge clk); #1 reset = 1;
    d_op(64'h100, 64'h0, 8'h00, 2'b00, rdata, exc, wrs);
    chk("t6_reload", rdata, 64'hAABBCCDD55667788);

    // randomized traffic
    gi = 1; gd = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!reset) reset = 1;
      else if ($urandom_range(0, 399) == 0) reset = 0;
      if (!(bus.i_req_valid && !gi) || $urandom_range(0, 19) == 0) begin
        bus.i_req_valid = ($urandom_range(0, 99) < 55);
        bus.i_req_pc = gen_addr();
      end
      if (!(bus.d_req_valid && !gd) || $urandom_range(0, 19) == 0) begin
        bus.d_req_valid = ($urandom_range(0, 99) < 60);
        bus.d_req_addr = gen_addr();
        bus.d_req_data = {$urandom, $urandom};
        bus.d_req_mask = 8'($urandom);
        bus.d_req_memo = 2'($urandom);
      end
      bus.i_rsp_ready = ($urandom_range(0, 99) < 70);
      bus.d_rsp_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      gi = bus.i_req_ready; gd = bus.d_req_ready;
    end
    @(posedge clk); #1;
    reset = 1; bus.i_req_valid = 0; bus.d_req_valid = 0;
    bus.i_rsp_ready = 1; bus.d_rsp_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
